// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and defaults for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;

  localparam int unsigned DATA_W_DEF         = 8;
  localparam int unsigned CNT_W_DEF          = 8;
  localparam int unsigned RD_LATENCY_DEF     = 1;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_READ    = 3'd2,
    ST_LAT     = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_DONE    = 3'd6
  } rd_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the sample FIFO / UART transmitter and fifo_rd_ctrl.
interface fifo_rd_ctrl_if
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic              start;
  logic [CNT_W-1:0]  send_time;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              tx_done;

  logic              fifo_rd_en;
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              send_done;
  logic              timeout_err;

  modport master (
    input  start, send_time, fifo_empty, fifo_rd_data, tx_done,
    output fifo_rd_en, tx_en, tx_data, busy, send_done, timeout_err
  );

  modport slave (
    output start, send_time, fifo_empty, fifo_rd_data, tx_done,
    input  fifo_rd_en, tx_en, tx_data, busy, send_done, timeout_err
  );

endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains send_time bytes from a standard-mode FIFO into uart_tx, one byte per tx_done.
// Optional empty-FIFO abort is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned RD_LATENCY     = RD_LATENCY_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ctrl_if.master bus
);

  localparam int unsigned LAT_W = 2;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  times_q, times_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  logic all_sent;
  logic timeout_hit;

  assign all_sent = (cnt_q == times_q);

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q, to_d;
  logic            to_run;

  assign to_run      = (state_q == ST_CHECK) && bus.fifo_empty && !all_sent;
  assign timeout_hit = to_run && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_d = '0;
    if (to_run && !timeout_hit) begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    times_d       = times_q;
    lat_d         = lat_q;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          times_d = bus.send_time;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      // Completion wins over the timeout so a finished transfer never aborts.
      ST_CHECK: begin
        if (all_sent) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (!bus.fifo_empty) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        lat_d   = LAT_W'(1);
        state_d = ST_LAT;
      end
      ST_LAT: begin
        if (lat_q == LAT_W'(RD_LATENCY)) begin
          tx_data_d = bus.fifo_rd_data;
          state_d   = ST_SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_SEND: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.tx_done) begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      times_q       <= '0;
      lat_q         <= '0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      times_q       <= times_d;
      lat_q         <= lat_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.fifo_rd_en  = (state_q == ST_READ);
  assign bus.tx_en       = (state_q == ST_SEND);
  assign bus.send_done   = (state_q == ST_DONE);
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
